// File: rtl/kart_pkg.sv
// Shared definitions for the opponent-state word exchanged over Ethernet:
// field positions, decoded state struct, reserved-bit mask and tracker states.
package kart_pkg;

    localparam int WORD_W   = 44;
    localparam int X_LSB    = 33;
    localparam int X_W      = 11;
    localparam int Y_LSB    = 21;
    localparam int Y_W      = 11;
    localparam int DIR_LSB  = 11;
    localparam int DIR_W    = 9;
    localparam int GAME_LSB = 5;
    localparam int GAME_W   = 3;
    localparam int RST_BIT  = 3;

    // Bits 32, 20, [10:8], 4 and [2:0] carry no field and must arrive as zero.
    localparam logic [WORD_W-1:0] RSVD_MASK = 44'h001_0010_0717;

    localparam logic [DIR_W-1:0] DIR_MAX = 9'd359;

    typedef struct packed {
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [DIR_W-1:0]  dir;
        logic [GAME_W-1:0] game;
        logic              rst;
    } opp_state_t;

    typedef enum logic [1:0] {
        DOWN   = 2'd0,
        CAND   = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

    function automatic opp_state_t decode_word(input logic [WORD_W-1:0] w);
        opp_state_t s;
        s.x    = w[X_LSB +: X_W];
        s.y    = w[Y_LSB +: Y_W];
        s.dir  = w[DIR_LSB +: DIR_W];
        s.game = w[GAME_LSB +: GAME_W];
        s.rst  = w[RST_BIT];
        return s;
    endfunction

endpackage

// File: rtl/opp_word_check.sv
// Combinational decode of one opponent-state word plus its validity check
// (non-zero, reserved bits clear, coordinates and heading in range).
module opp_word_check
    import kart_pkg::*;
#(
    parameter int MAX_COORD = 1023
) (
    input  logic              axiov,
    input  logic [WORD_W-1:0] axiod,
    output opp_state_t        word,
    output logic              valid
);

    localparam logic [X_W-1:0] MAX_X = X_W'(MAX_COORD);
    localparam logic [Y_W-1:0] MAX_Y = Y_W'(MAX_COORD);

    always_comb begin
        word  = decode_word(axiod);
        valid = axiov
             && (axiod != '0)
             && ((axiod & RSVD_MASK) == '0)
             && (word.x <= MAX_X)
             && (word.y <= MAX_Y)
             && (word.dir <= DIR_MAX);
    end

endmodule

// File: rtl/opponent_rx_tracker.sv
// Debounces opponent-state words into a committed kart state with link timeout.
// Define OPP_RX_STATS_EN to add saturating reject/commit/timeout counters.
module opponent_rx_tracker
    import kart_pkg::*;
#(
    parameter int CONFIRM_CNT    = 2,
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter int MAX_COORD      = 1023
) (
    input  logic              clk_in,
    input  logic              rst_in_n,
    input  logic              axiov,
    input  logic [WORD_W-1:0] axiod,
    output logic [X_W-1:0]    opp_x,
    output logic [Y_W-1:0]    opp_y,
    output logic [DIR_W-1:0]  opp_dir,
    output logic [GAME_W-1:0] opp_game,
    output logic              opp_reset_pulse,
    output logic              update_pulse,
    output logic              link_up
`ifdef OPP_RX_STATS_EN
    ,
    output logic [15:0]       stat_rejects,
    output logic [15:0]       stat_commits,
    output logic [15:0]       stat_timeouts
`endif
);

    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]        CONFIRM  = 4'(CONFIRM_CNT);

    rx_state_t         state_reg, state_next;
    opp_state_t        cand_reg, cand_next;
    logic [3:0]        match_reg, match_next;
    logic [IDLE_W-1:0] idle_reg, idle_next;
    logic              rst_flag_reg;

    opp_state_t        word;
    logic              valid;
    logic              commit;
    logic              refresh;
    logic              timeout;

    opp_word_check #(
        .MAX_COORD (MAX_COORD)
    ) u_check (
        .axiov (axiov),
        .axiod (axiod),
        .word  (word),
        .valid (valid)
    );

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_reg <= DOWN;
            cand_reg  <= '0;
            match_reg <= '0;
            idle_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cand_reg  <= cand_next;
            match_reg <= match_next;
            idle_reg  <= idle_next;
        end
    end

    // A valid word always takes precedence over a timeout in the same cycle.
    always_comb begin
        state_next = state_reg;
        cand_next  = cand_reg;
        match_next = match_reg;
        commit     = 1'b0;
        refresh    = 1'b0;
        timeout    = 1'b0;

        if (valid) begin
            if ((state_reg == DOWN) || (word != cand_reg)) begin
                cand_next  = word;
                match_next = 4'd1;
                if (CONFIRM == 4'd1) begin
                    commit = 1'b1;
                end else if (state_reg == DOWN) begin
                    state_next = CAND;
                end
            end else if (match_reg < CONFIRM) begin
                match_next = match_reg + 4'd1;
                if ((match_reg + 4'd1) == CONFIRM) begin
                    commit = 1'b1;
                end
            end else if (state_reg == LOCKED) begin
                refresh = 1'b1;
            end
            if (commit) begin
                state_next = LOCKED;
            end
        end else if ((state_reg != DOWN) && (idle_reg == IDLE_MAX)) begin
            timeout    = 1'b1;
            state_next = DOWN;
            cand_next  = '0;
            match_next = '0;
        end
    end

    always_comb begin
        idle_next = idle_reg;
        if (commit || refresh) begin
            idle_next = '0;
        end else if (idle_reg != IDLE_MAX) begin
            idle_next = idle_reg + 1'b1;
        end
    end

    // On every commit path the incoming word equals the state being committed.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            opp_x           <= '0;
            opp_y           <= '0;
            opp_dir         <= '0;
            opp_game        <= '0;
            rst_flag_reg    <= 1'b0;
            update_pulse    <= 1'b0;
            opp_reset_pulse <= 1'b0;
            link_up         <= 1'b0;
        end else begin
            update_pulse    <= commit;
            opp_reset_pulse <= commit && word.rst && !rst_flag_reg;
            if (commit) begin
                opp_x        <= word.x;
                opp_y        <= word.y;
                opp_dir      <= word.dir;
                opp_game     <= word.game;
                rst_flag_reg <= word.rst;
            end
            if (commit || refresh) begin
                link_up <= 1'b1;
            end else if (timeout) begin
                link_up <= 1'b0;
            end
        end
    end

`ifdef OPP_RX_STATS_EN
    logic reject;
    assign reject = axiov && (axiod != '0) && !valid;

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            stat_rejects  <= '0;
            stat_commits  <= '0;
            stat_timeouts <= '0;
        end else begin
            if (reject && (stat_rejects != 16'hFFFF)) begin
                stat_rejects <= stat_rejects + 16'd1;
            end
            if (commit && (stat_commits != 16'hFFFF)) begin
                stat_commits <= stat_commits + 16'd1;
            end
            if (timeout && (stat_timeouts != 16'hFFFF)) begin
                stat_timeouts <= stat_timeouts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_opponent_rx_tracker.sv
// Directed scenarios plus randomized traffic for opponent_rx_tracker, checked
// every cycle against a rule-level model of the debounce/commit/timeout behaviour.
module tb_opponent_rx_tracker;

    localparam int CONFIRM = 2;
    localparam int TMO     = 100;
    localparam int MAXC    = 1000;

    logic        clk_in   = 1'b0;
    logic        rst_in_n = 1'b0;
    logic        axiov    = 1'b0;
    logic [43:0] axiod    = '0;
    logic [10:0] opp_x;
    logic [10:0] opp_y;
    logic [8:0]  opp_dir;
    logic [2:0]  opp_game;
    logic        opp_reset_pulse;
    logic        update_pulse;
    logic        link_up;
`ifdef OPP_RX_STATS_EN
    logic [15:0] stat_rejects;
    logic [15:0] stat_commits;
    logic [15:0] stat_timeouts;
`endif

    opponent_rx_tracker #(
        .CONFIRM_CNT    (CONFIRM),
        .TIMEOUT_CYCLES (TMO),
        .MAX_COORD      (MAXC)
    ) dut (
        .clk_in          (clk_in),
        .rst_in_n        (rst_in_n),
        .axiov           (axiov),
        .axiod           (axiod),
        .opp_x           (opp_x),
        .opp_y           (opp_y),
        .opp_dir         (opp_dir),
        .opp_game        (opp_game),
        .opp_reset_pulse (opp_reset_pulse),
        .update_pulse    (update_pulse),
        .link_up         (link_up)
`ifdef OPP_RX_STATS_EN
        ,
        .stat_rejects    (stat_rejects),
        .stat_commits    (stat_commits),
        .stat_timeouts   (stat_timeouts)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending candidate word, its repeat count, committed view.
    logic [43:0] m_cand;
    bit          m_have, m_locked, m_rflag, m_link, m_upd, m_rp;
    int          m_cnt, m_idle, m_x, m_y, m_dir, m_game;

    function automatic logic [43:0] make_word(input int x, input int y, input int dir,
                                              input int game, input int r);
        logic [43:0] w;
        w = (44'(x) << 33) | (44'(y) << 21) | (44'(dir) << 11) | (44'(game) << 5) | (44'(r) << 3);
        return w;
    endfunction

    function automatic bit word_ok(input bit v, input logic [43:0] w);
        int x, y, dir;
        if (!v || w == 44'd0) return 1'b0;
        if (w[32] || w[20] || w[10] || w[9] || w[8] || w[4] || w[2] || w[1] || w[0]) return 1'b0;
        x   = int'(w[43:33]);
        y   = int'(w[31:21]);
        dir = int'(w[19:11]);
        return (x <= MAXC) && (y <= MAXC) && (dir <= 359);
    endfunction

    task automatic model_reset();
        m_cand = '0; m_have = 0; m_locked = 0; m_rflag = 0; m_link = 0;
        m_upd = 0; m_rp = 0; m_cnt = 0; m_idle = 0;
        m_x = 0; m_y = 0; m_dir = 0; m_game = 0;
    endtask

    task automatic model_step(input bit v, input logic [43:0] d);
        bit commit, refresh;
        commit  = 0;
        refresh = 0;
        if (word_ok(v, d)) begin
            if (!m_have || d != m_cand) begin
                m_cand = d;
                m_cnt  = 1;
                m_have = 1;
                if (CONFIRM == 1) commit = 1;
            end else if (m_cnt < CONFIRM) begin
                m_cnt++;
                if (m_cnt == CONFIRM) commit = 1;
            end else if (m_locked) begin
                refresh = 1;
            end
            if (commit) m_locked = 1;
        end else if (m_have && m_idle == TMO - 1) begin
            m_have = 0; m_locked = 0; m_cnt = 0; m_cand = '0; m_link = 0;
        end
        m_upd = commit;
        m_rp  = commit && d[3] && !m_rflag;
        if (commit) begin
            m_x = int'(d[43:33]); m_y = int'(d[31:21]);
            m_dir = int'(d[19:11]); m_game = int'(d[7:5]);
            m_rflag = d[3];
        end
        if (commit || refresh) begin
            m_idle = 0;
            m_link = 1;
        end else if (m_idle < TMO - 1) begin
            m_idle++;
        end
    endtask

    task automatic check_outputs();
        check_val("opp_x", 64'(opp_x), 64'(m_x));
        check_val("opp_y", 64'(opp_y), 64'(m_y));
        check_val("opp_dir", 64'(opp_dir), 64'(m_dir));
        check_val("opp_game", 64'(opp_game), 64'(m_game));
        check_val("update_pulse", 64'(update_pulse), 64'(m_upd));
        check_val("opp_reset_pulse", 64'(opp_reset_pulse), 64'(m_rp));
        check_val("link_up", 64'(link_up), 64'(m_link));
    endtask

    task automatic do_cycle(input bit v, input logic [43:0] d);
        axiov = v;
        axiod = d;
        @(posedge clk_in);
        model_step(v, d);
        #1;
        check_outputs();
    endtask

    task automatic apply_reset();
        rst_in_n = 1'b0;
        model_reset();
        #2;
        check_outputs();
        @(posedge clk_in);
        #1;
        rst_in_n = 1'b1;
    endtask

    logic [43:0] wa, wb, w0, w1, w2, w3, d;
    logic [43:0] pool [4];
    logic [63:0] raw;
    int          rp_count, r, idx;
    int          rsvd_bits [9] = '{32, 20, 10, 9, 8, 4, 2, 1, 0};

    initial begin
        model_reset();
        #12;
        check_val("reset_link", 64'(link_up), 64'd0);
        check_val("reset_x", 64'(opp_x), 64'd0);
        apply_reset();

        // Two identical words commit one cycle after the second.
        wa = make_word(191, 191, 270, 1, 0);
        do_cycle(1, wa);
        check_val("t1_no_early_upd", 64'(update_pulse), 64'd0);
        do_cycle(1, wa);
        check_val("t1_upd", 64'(update_pulse), 64'd1);
        check_val("t1_x", 64'(opp_x), 64'd191);
        check_val("t1_y", 64'(opp_y), 64'd191);
        check_val("t1_dir", 64'(opp_dir), 64'd270);
        check_val("t1_game", 64'(opp_game), 64'd1);
        check_val("t1_link", 64'(link_up), 64'd1);
        do_cycle(0, '0);
        check_val("t1_upd_one_cycle", 64'(update_pulse), 64'd0);
        $display("scenario basic_commit done");

        // Alternating words never confirm.
        apply_reset();
        for (int i = 0; i < 10; i++) do_cycle(1, make_word(100 + (i % 2), 50, 90, 2, 0));
        check_val("t2_x", 64'(opp_x), 64'd0);
        check_val("t2_link", 64'(link_up), 64'd0);
        $display("scenario alternation done");

        // Invalid words between two matching words are transparent.
        apply_reset();
        wb = make_word(300, 400, 10, 3, 0);
        do_cycle(1, wb);
        do_cycle(1, wb | 44'h1);
        do_cycle(1, make_word(300, 400, 360, 3, 0));
        do_cycle(1, make_word(1023, 400, 10, 3, 0));
        do_cycle(1, '0);
        do_cycle(1, wb);
        check_val("t3_upd", 64'(update_pulse), 64'd1);
        check_val("t3_x", 64'(opp_x), 64'd300);
        check_val("t3_y", 64'(opp_y), 64'd400);
        $display("scenario invalid_words done");

        // Reset flag 0 -> 1 -> 1 across commits yields one pulse.
        apply_reset();
        w0 = make_word(10, 20, 30, 4, 0);
        w1 = make_word(10, 20, 30, 4, 1);
        w2 = make_word(11, 20, 30, 4, 1);
        rp_count = 0;
        do_cycle(1, w0); rp_count += int'(opp_reset_pulse);
        do_cycle(1, w0); rp_count += int'(opp_reset_pulse);
        do_cycle(1, w1); rp_count += int'(opp_reset_pulse);
        do_cycle(1, w1);
        check_val("t4_rp_first", 64'(opp_reset_pulse), 64'd1);
        rp_count += int'(opp_reset_pulse);
        do_cycle(1, w2); rp_count += int'(opp_reset_pulse);
        do_cycle(1, w2); rp_count += int'(opp_reset_pulse);
        check_val("t4_upd_w2", 64'(update_pulse), 64'd1);
        do_cycle(0, '0); rp_count += int'(opp_reset_pulse);
        check_val("t4_rp_count", 64'(rp_count), 64'd1);
        $display("scenario reset_flag done");

        // Silence after lock: link drops at cycle TMO after the commit.
        apply_reset();
        do_cycle(1, w2);
        do_cycle(1, w2);
        for (int i = 1; i < TMO; i++) do_cycle(0, '0);
        check_val("t5_link_before", 64'(link_up), 64'd1);
        do_cycle(0, '0);
        check_val("t5_link_after", 64'(link_up), 64'd0);
        check_val("t5_x_hold", 64'(opp_x), 64'd11);
        w3 = make_word(500, 600, 180, 5, 0);
        do_cycle(1, w3);
        do_cycle(1, w3);
        check_val("t5_relock", 64'(link_up), 64'd1);
        for (int i = 1; i < TMO - 1; i++) do_cycle(0, '0);
        do_cycle(1, w3);
        check_val("t5_refresh_no_upd", 64'(update_pulse), 64'd0);
        for (int i = 0; i < 60; i++) do_cycle(0, '0);
        check_val("t5_link_kept", 64'(link_up), 64'd1);
        $display("scenario timeout done");

        // Reset between two identical words discards the first.
        apply_reset();
        do_cycle(1, wa);
        apply_reset();
        do_cycle(1, wa);
        check_val("t6_no_commit", 64'(update_pulse), 64'd0);
        do_cycle(1, wa);
        check_val("t6_commit", 64'(update_pulse), 64'd1);
        $display("scenario mid_reset done");

        // Randomized traffic from a small pool so that matches are frequent.
        for (int k = 0; k < 4000; k++) begin
            if (k % 500 == 0) begin
                for (int p = 0; p < 4; p++) begin
                    pool[p] = make_word($urandom_range(0, MAXC), $urandom_range(0, MAXC),
                                        $urandom_range(0, 359), $urandom_range(0, 7),
                                        $urandom_range(0, 1));
                end
            end
            if ($urandom_range(0, 499) == 0) begin
                apply_reset();
            end else if ($urandom_range(0, 199) == 0) begin
                for (int g = 0; g < TMO + 20; g++) do_cycle(0, '0);
            end
            r = $urandom_range(0, 99);
            idx = $urandom_range(0, 3);
            if (r < 50) begin
                do_cycle(1, pool[idx]);
            end else if (r < 65) begin
                d = pool[idx];
                case ($urandom_range(0, 3))
                    0: d[rsvd_bits[$urandom_range(0, 8)]] = 1'b1;
                    1: d[19:11] = 9'($urandom_range(360, 511));
                    2: d[43:33] = 11'($urandom_range(MAXC + 1, 2047));
                    default: d = '0;
                endcase
                do_cycle(1, d);
            end else if (r < 75) begin
                raw = {$urandom(), $urandom()};
                do_cycle(1, raw[43:0]);
            end else begin
                raw = {$urandom(), $urandom()};
                do_cycle(0, raw[43:0]);
            end
        end
        $display("scenario random done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
